// File: rtl/plate_pkg.sv
// Shared types and helpers for the plate edge locator.
//   COORD_W : coordinate / counter width
//   H_ACT   : active pixels per line
//   V_ACT   : active lines per frame
//   RUN_W   : width of the hot-row run and gap counters
package plate_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned H_ACT   = 480;
  localparam int unsigned V_ACT   = 272;
  localparam int unsigned RUN_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Inclusive window test on unsigned coordinates.
  function automatic logic in_range(input logic [COORD_W-1:0] v,
                                    input logic [COORD_W-1:0] lo,
                                    input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic [COORD_W-1:0] cmin(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [COORD_W-1:0] cmax(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/row_stat_acc.sv
// Per-row mask statistics: count, min x, max x and row y, with a row-end strobe.
//   clk, rst      : pixel clock, synchronous active-high reset
//   x, y          : current pixel coordinates
//   de, mask      : active-video enable and plate-colour mask
//   frame_start   : discards the row in progress
//   row_cnt       : qualified mask pixels in the row (saturating)
//   row_lo/row_hi : min/max qualified mask x (12'hFFF / 0 when empty)
//   row_y         : y of the last de cycle of the row
//   row_end_c     : combinational strobe, valid on the cycle after the last de pixel
module row_stat_acc
  import plate_pkg::*;
#(
  parameter logic [COORD_W-1:0] X_MIN = 12'd1,
  parameter logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACT),
  parameter logic [COORD_W-1:0] Y_MIN = 12'd0,
  parameter logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACT - 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               de,
  input  logic               mask,
  input  logic               frame_start,
  output logic [COORD_W-1:0] row_cnt,
  output logic [COORD_W-1:0] row_lo,
  output logic [COORD_W-1:0] row_hi,
  output logic [COORD_W-1:0] row_y,
  output logic               row_end_c
);

  logic de_d;
  logic drop;  // row straddled a frame start; its end is not reported
  logic pix;

  assign pix       = de && mask && in_range(x, X_MIN, X_MAX) && in_range(y, Y_MIN, Y_MAX);
  assign row_end_c = de_d && !de && !drop;

  // Accumulators clear on the edge that ends the row, so they are fresh for the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_d    <= 1'b0;
      drop    <= 1'b0;
      row_cnt <= '0;
      row_lo  <= '1;
      row_hi  <= '0;
      row_y   <= '0;
    end else begin
      de_d <= de;
      if (de) begin
        row_y <= y;
      end
      if (frame_start) begin
        drop    <= de;
        row_cnt <= '0;
        row_lo  <= '1;
        row_hi  <= '0;
      end else if (de_d && !de) begin
        drop    <= 1'b0;
        row_cnt <= '0;
        row_lo  <= '1;
        row_hi  <= '0;
      end else if (pix) begin
        row_cnt <= (row_cnt == '1) ? row_cnt : row_cnt + COORD_W'(1);
        row_lo  <= cmin(row_lo, x);
        row_hi  <= cmax(row_hi, x);
      end
    end
  end

endmodule

// File: rtl/plate_edge_locator.sv
// Per-frame licence-plate band locator; publishes the band edges at each frame start.
//   clk, rst        : pixel clock, synchronous active-high reset
//   x, y            : pixel coordinates
//   i_vs, i_de      : vertical sync, active-video enable
//   i_mask          : plate-colour mask pixel
//   edge_left/right : min/max mask x of the band
//   edge_up/dowm    : first row / last hot row of the band
//   edge_valid      : edges come from a frame that had a qualified band
//   frame_done      : one-cycle pulse when the edge outputs update
module plate_edge_locator
  import plate_pkg::*;
#(
  parameter logic [COORD_W-1:0] ROW_TH  = 12'd40,
  parameter logic [RUN_W-1:0]   MIN_RUN = 4'd4,
  parameter logic [RUN_W-1:0]   MAX_GAP = 4'd2,
  parameter logic [COORD_W-1:0] X_MIN   = 12'd1,
  parameter logic [COORD_W-1:0] X_MAX   = COORD_W'(H_ACT),
  parameter logic [COORD_W-1:0] Y_MIN   = 12'd0,
  parameter logic [COORD_W-1:0] Y_MAX   = COORD_W'(V_ACT - 1),
  parameter logic               VS_POL  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               i_vs,
  input  logic               i_de,
  input  logic               i_mask,
  output logic [COORD_W-1:0] edge_left,
  output logic [COORD_W-1:0] edge_right,
  output logic [COORD_W-1:0] edge_up,
  output logic [COORD_W-1:0] edge_dowm,
  output logic               edge_valid,
  output logic               frame_done
);

  state_t             state;
  logic               vs_d;
  logic               frame_start;
  logic [COORD_W-1:0] row_cnt, row_lo, row_hi, row_y;
  logic               row_end;
  logic               row_hot;

  logic [RUN_W-1:0]   run, gap;
  logic [RUN_W-1:0]   run_n, gap_n;
  logic [COORD_W-1:0] run_start, run_lo, run_hi;
  logic [COORD_W-1:0] start_n, lo_n, hi_n;
  logic [COORD_W-1:0] band_left, band_right, band_up, band_dowm;
  logic               found;

  row_stat_acc #(
    .X_MIN(X_MIN),
    .X_MAX(X_MAX),
    .Y_MIN(Y_MIN),
    .Y_MAX(Y_MAX)
  ) u_row (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .de         (i_de),
    .mask       (i_mask),
    .frame_start(frame_start),
    .row_cnt    (row_cnt),
    .row_lo     (row_lo),
    .row_hi     (row_hi),
    .row_y      (row_y),
    .row_end_c  (row_end)
  );

  assign frame_start = (i_vs == VS_POL) && (vs_d != VS_POL);
  assign row_hot     = (row_cnt >= ROW_TH) && in_range(row_y, Y_MIN, Y_MAX);

  // Run merge: the first row of a run seeds start/min/max.
  assign run_n   = run + RUN_W'(1);
  assign gap_n   = (gap == '1) ? gap : gap + RUN_W'(1);
  assign start_n = (run == '0) ? row_y  : run_start;
  assign lo_n    = (run == '0) ? row_lo : cmin(run_lo, row_lo);
  assign hi_n    = (run == '0) ? row_hi : cmax(run_hi, row_hi);

  // Band search FSM; frame start has priority over a coincident row end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vs_d       <= VS_POL;
      frame_done <= 1'b0;
      edge_left  <= '0;
      edge_right <= '0;
      edge_up    <= '0;
      edge_dowm  <= '0;
      edge_valid <= 1'b0;
      run        <= '0;
      gap        <= '0;
      run_start  <= '0;
      run_lo     <= '1;
      run_hi     <= '0;
      band_left  <= '0;
      band_right <= '0;
      band_up    <= '0;
      band_dowm  <= '0;
      found      <= 1'b0;
    end else begin
      vs_d       <= i_vs;
      frame_done <= 1'b0;
      if (frame_start) begin
        frame_done <= 1'b1;
        if (found) begin
          edge_left  <= band_left;
          edge_right <= band_right;
          edge_up    <= band_up;
          edge_dowm  <= band_dowm;
          edge_valid <= 1'b1;
        end else begin
          edge_valid <= 1'b0;
        end
        run        <= '0;
        gap        <= '0;
        run_start  <= '0;
        run_lo     <= '1;
        run_hi     <= '0;
        band_left  <= '0;
        band_right <= '0;
        band_up    <= '0;
        band_dowm  <= '0;
        found      <= 1'b0;
        state      <= SEARCH;
      end else if (row_end) begin
        case (state)
          SEARCH: begin
            if (row_hot) begin
              run       <= run_n;
              run_start <= start_n;
              run_lo    <= lo_n;
              run_hi    <= hi_n;
              if (run_n == MIN_RUN) begin
                band_up    <= start_n;
                band_left  <= lo_n;
                band_right <= hi_n;
                band_dowm  <= row_y;
                found      <= 1'b1;
                gap        <= '0;
                state      <= TRACK;
              end
            end else begin
              run    <= '0;
              run_lo <= '1;
              run_hi <= '0;
            end
          end
          TRACK: begin
            if (row_hot) begin
              band_dowm  <= row_y;
              band_left  <= cmin(band_left, row_lo);
              band_right <= cmax(band_right, row_hi);
              gap        <= '0;
            end else begin
              gap <= gap_n;
              if (gap_n > MAX_GAP) begin
                state <= DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
